// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: next-PC select codes
// and the priority function that picks one from the control requests.
package pc_pkg;

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_JMP  = 3'd2;
  localparam logic [2:0] SEL_RET  = 3'd3;
  localparam logic [2:0] SEL_HOLD = 3'd4;

  // Priority: stall > ret > call/jmp > branch > sequential.
  function automatic logic [2:0] pc_next_sel(
    input logic stall_i,
    input logic ret_i,
    input logic call_i,
    input logic jmp_i,
    input logic br_taken_i
  );
    logic [2:0] sel;
    if (stall_i) begin
      sel = SEL_HOLD;
    end else if (ret_i) begin
      sel = SEL_RET;
    end else if (call_i || jmp_i) begin
      sel = SEL_JMP;
    end else if (br_taken_i) begin
      sel = SEL_BR;
    end else begin
      sel = SEL_SEQ;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored apart from the sticky underflow flag.
module ras_stack #(
  parameter  int unsigned PC_W      = 9,
  parameter  int unsigned RAS_DEPTH = 4,
  localparam int unsigned PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  push_data,
  output logic [PC_W-1:0]  top_data,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(RAS_DEPTH);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d, wr_ptr_s;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  assign wr_ptr_s = top_q + PTR_W'(1);
  assign empty    = (cnt_q == {(PTR_W+1){1'b0}});
  assign full     = (cnt_q == CNT_MAX);

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push) begin
      top_d = wr_ptr_s;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (PTR_W+1)'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - (PTR_W+1)'(1);
      end
    end else begin
      top_d = top_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= {PTR_W{1'b0}};
      cnt_q <= {(PTR_W+1){1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_s] <= push_data;
    end
  end

  assign top_data = mem_q[top_q];
  assign count    = cnt_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with stall, branch, jump, call and return redirection;
// return addresses come from the internal circular stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter  int unsigned     PC_W      = 9,
  parameter  logic [PC_W-1:0] RESET_VEC = {PC_W{1'b0}},
  parameter  int unsigned     RAS_DEPTH = 4,
  localparam int unsigned     RAS_PTR_W = $clog2(RAS_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [PC_W-1:0]      br_target,
  input  logic                 jmp,
  input  logic [PC_W-1:0]      jmp_target,
  input  logic                 call,
  input  logic                 ret,
  output logic [PC_W-1:0]      pc,
  output logic [PC_W-1:0]      pc_plus1,
  output logic [RAS_PTR_W:0]   ras_count,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 ras_ovf,
  output logic                 ras_unf
);

  logic [2:0]      sel_s;
  logic [PC_W-1:0] pc_q, pc_d, ras_top_s;
  logic            push_s, pop_s;

  assign sel_s    = pc_next_sel(stall, ret, call, jmp, br_taken);
  assign pc_plus1 = pc_q + PC_W'(1);
  // ret outranks call, so a push only happens on the jump path.
  assign push_s   = (sel_s == SEL_JMP) && call;
  assign pop_s    = (sel_s == SEL_RET);

  always_comb begin
    pc_d = pc_plus1;
    case (sel_s)
      SEL_HOLD: pc_d = pc_q;
      SEL_RET:  pc_d = ras_empty ? pc_plus1 : ras_top_s;
      SEL_JMP:  pc_d = jmp_target;
      SEL_BR:   pc_d = br_target;
      SEL_SEQ:  pc_d = pc_plus1;
      default:  pc_d = pc_plus1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_plus1),
    .top_data  (ras_top_s),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit (PC_W=9, RESET_VEC=0, RAS_DEPTH=4).
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic [8:0] br_target = 9'h000;
  logic       jmp = 1'b0;
  logic [8:0] jmp_target = 9'h000;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [8:0] pc, pc_plus1;
  logic [2:0] ras_count;
  logic       ras_empty, ras_full, ras_ovf, ras_unf;

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit #(.PC_W(9), .RESET_VEC(9'h000), .RAS_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .call       (call),
    .ret        (ret),
    .pc         (pc),
    .pc_plus1   (pc_plus1),
    .ras_count  (ras_count),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, stall, ret, call, jmp, br;
    logic [8:0] br_t, jmp_t;
    logic [8:0] e_pc;
    logic [2:0] e_cnt;
    logic       e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, s, rt, c, j, b,
                              input logic [8:0] bt, jt, epc,
                              input logic [2:0] ec, input logic eo, eu);
    vec_t v;
    v.rst = r; v.stall = s; v.ret = rt; v.call = c; v.jmp = j; v.br = b;
    v.br_t = bt; v.jmp_t = jt; v.e_pc = epc; v.e_cnt = ec; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests at negedge, check state just after the next posedge.
  task automatic step(input string tag, input vec_t v);
    logic [8:0] e_pp1;
    @(negedge clk);
    rst = v.rst; stall = v.stall; ret = v.ret; call = v.call; jmp = v.jmp;
    br_taken = v.br; br_target = v.br_t; jmp_target = v.jmp_t;
    @(posedge clk);
    #1;
    e_pp1 = v.e_pc + 9'd1;
    chk({tag, " pc"},        {23'd0, pc},        {23'd0, v.e_pc});
    chk({tag, " pc_plus1"},  {23'd0, pc_plus1},  {23'd0, e_pp1});
    chk({tag, " ras_count"}, {29'd0, ras_count}, {29'd0, v.e_cnt});
    chk({tag, " ras_empty"}, {31'd0, ras_empty}, {31'd0, (v.e_cnt == 3'd0)});
    chk({tag, " ras_full"},  {31'd0, ras_full},  {31'd0, (v.e_cnt == 3'd4)});
    chk({tag, " ras_ovf"},   {31'd0, ras_ovf},   {31'd0, v.e_ovf});
    chk({tag, " ras_unf"},   {31'd0, ras_unf},   {31'd0, v.e_unf});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //               rst  stl  ret  cal  jmp  br   br_t    jmp_t   pc      cnt   ovf  unf
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,9'h000,9'h000,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,9'h000,9'h001,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,9'h000,9'h002,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,9'h000,9'h003,3'd0,1'b0,1'b0));
    // wrap-around from all-ones
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'h000,9'h1FF,9'h1FF,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,9'h000,9'h000,3'd0,1'b0,1'b0));
    // jmp beats br_taken, then two stalls hold
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'h000,9'h010,9'h010,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,9'h080,9'h040,9'h040,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,9'h080,9'h000,9'h040,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,9'h000,9'h123,9'h040,3'd0,1'b0,1'b0));
    // call chain 0x010 -> 0x020 -> 0x030 -> 0x100, then three returns
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'h000,9'h010,9'h010,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,9'h000,9'h020,9'h020,3'd1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,9'h0EE,9'h030,9'h030,3'd2,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,9'h000,9'h100,9'h100,3'd3,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,9'h0EE,9'h000,9'h031,3'd2,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h021,3'd1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h011,3'd0,1'b0,1'b0));
    // five calls from 0x10..0x14 overflow a 4-deep stack
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'h000,9'h010,9'h010,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'h000,9'h011,9'h011,3'd1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'h000,9'h012,9'h012,3'd2,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'h000,9'h013,9'h013,3'd3,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'h000,9'h014,9'h014,3'd4,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'h000,9'h015,9'h015,3'd4,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h015,3'd3,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h014,3'd2,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h013,3'd1,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h012,3'd0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h013,3'd0,1'b1,1'b1));
    // reset clears sticky flags; call+ret with one entry: ret wins, no push
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,9'h000,9'h000,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'h000,9'h054,9'h054,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,9'h000,9'h1A0,9'h1A0,3'd1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,9'h0BB,9'h0AA,9'h055,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,9'h0C0,9'h000,9'h0C0,3'd0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h0C1,3'd0,1'b0,1'b1));
    // call from all-ones pushes 0, which must come back intact
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'h000,9'h1FF,9'h1FF,3'd0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'h000,9'h005,9'h005,3'd1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h000,3'd0,1'b0,1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Hand sequence: build count=2, stall, then reset in the middle of a stall
    // with call+ret also asserted; reset must win everything.
    step("rs_call1", mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'h000,9'h030,9'h030,3'd1,1'b0,1'b1));
    step("rs_call2", mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'h000,9'h040,9'h040,3'd2,1'b0,1'b1));
    step("rs_stall", mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,9'h000,9'h000,9'h040,3'd2,1'b0,1'b1));
    step("rs_rst",   mk(1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,9'h0BB,9'h077,9'h000,3'd0,1'b0,1'b0));
    step("rs_idle",  mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,9'h000,9'h001,3'd0,1'b0,1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
